// File: rtl/deserialize_pkg.sv
// Shared constants and helpers for the deserialize slice.
// Optional early end-of-transfer support is enabled with DESERIALIZE_EOT_EN.
package deserialize_pkg;

`ifdef DESERIALIZE_EOT_EN
  localparam int EOT_W = 1;
`else
  localparam int EOT_W = 0;
`endif

  function automatic int cnt_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/deserialize_if.sv
// Data/valid/ready stream interface used on both sides of the deserializer.
interface dti #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/deserialize_word_reg.sv
// Output holding register: loads a complete word and presents it on a dti stream.
// out_free_o tells the loader a word may be written this cycle without loss.
module dti_word_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  dti.producer         out,
  output logic         out_free_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // A load wins over a consume so a same-cycle handoff leaves no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (valid_q && out.ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Payload register, only written on a load.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign out.valid  = valid_q;
  assign out.data   = data_q;
  assign out_free_o = ~valid_q | out.ready;

endmodule

// File: rtl/deserialize.sv
// Gathers DOUT/DIN chunks (LSB first) into one DOUT-bit word on a dti stream.
// With DESERIALIZE_EOT_EN each chunk carries an eot MSB that ends the word early.
module deserialize
  import deserialize_pkg::*;
#(
  parameter int DIN  = 8,
  parameter int DOUT = 32
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din,
  dti.producer dout
);

  localparam int RATIO = DOUT / DIN;
  localparam int CW    = cnt_width(RATIO);
  localparam int AW    = (RATIO - 1) * DIN;

  generate
    if (DIN < 1 || (DOUT % DIN) != 0 || (DOUT / DIN) < 2) begin : g_bad_params
      $error("deserialize: DOUT must be a multiple of DIN with DOUT/DIN >= 2");
    end
  endgenerate

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [DIN-1:0]        payload_s;
  logic [DOUT-1:0]       data_s;
  logic [DOUT+EOT_W-1:0] word_s;
  logic                  last_s, eot_s, complete_s, accept_s, load_s, out_free_s;

  assign payload_s = din.data[DIN-1:0];
  assign last_s    = (cnt_q == CW'(RATIO - 1));
`ifdef DESERIALIZE_EOT_EN
  assign eot_s     = din.data[DIN];
  assign word_s    = {eot_s, data_s};
`else
  assign eot_s     = 1'b0;
  assign word_s    = data_s;
`endif
  assign complete_s = last_s | eot_s;
  assign din.ready  = ~complete_s | out_free_s;
  assign accept_s   = din.valid & din.ready;
  assign load_s     = accept_s & complete_s;

  // Word assembly: filled slots from acc, current chunk at cnt, zeros above it.
  always_comb begin
    data_s = {DOUT{1'b0}};
    for (int k = 0; k < RATIO - 1; k++) begin
      data_s[k*DIN +: DIN] = (k < int'(cnt_q)) ? acc_q[k*DIN +: DIN] : {DIN{1'b0}};
    end
    for (int k = 0; k < RATIO; k++) begin
      data_s[k*DIN +: DIN] = (k == int'(cnt_q)) ? payload_s : data_s[k*DIN +: DIN];
    end
  end

  // Next-state for the chunk index and the partial-word accumulator.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int k = 0; k < RATIO - 1; k++) begin
      acc_d[k*DIN +: DIN] = (accept_s && !complete_s && k == int'(cnt_q))
                            ? payload_s : acc_q[k*DIN +: DIN];
    end
    if (accept_s) begin
      cnt_d = complete_s ? {CW{1'b0}} : cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Chunk index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Accumulator holds data only; stale slots are masked at assembly.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  dti_word_reg #(
    .W (DOUT + EOT_W)
  ) u_word_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .data_i     (word_s),
    .out        (dout),
    .out_free_o (out_free_s)
  );

endmodule

// File: tb/tb_deserialize.sv
// Directed and randomized self-checking bench for deserialize (DIN=8, DOUT=32).
module tb_deserialize;
  import deserialize_pkg::*;

  localparam int DWI = 8 + EOT_W;
  localparam int DWO = 32 + EOT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  dti #(.W(DWI)) din_if ();
  dti #(.W(DWO)) dout_if ();

  deserialize #(.DIN(8), .DOUT(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one chunk, expecting it to be accepted in this cycle.
  task automatic send(input logic [DWI-1:0] b);
    din_if.valid = 1'b1;
    din_if.data  = b;
    #1;
    check("din_ready", 64'(din_if.ready), 64'd1);
    tick();
    din_if.valid = 1'b0;
  endtask

  logic [7:0]  seq8 [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [31:0] exp_q [$];
  logic [31:0] cur_word;
  logic [31:0] exp_w;
  int          ci, sent, rcv, cycles;
  logic        hs_in, hs_out;

  initial begin
    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_dout_valid", 64'(dout_if.valid), 64'd0);
    check("rst_din_ready", 64'(din_if.ready), 64'd1);

    // Two back-to-back words with an always-ready sink.
    for (int i = 0; i < 8; i++) begin
      send(DWI'(seq8[i]));
      check("b2b_valid", 64'(dout_if.valid), 64'((i == 3) || (i == 7)));
      if (i == 3) check("word0", 64'(dout_if.data), 64'h0_DDCC_BBAA);
      if (i == 7) check("word1", 64'(dout_if.data), 64'h0_4433_2211);
    end
    tick();
    check("drain_valid", 64'(dout_if.valid), 64'd0);

    // Stall at the last chunk while the previous word waits.
    for (int i = 0; i < 4; i++) send(DWI'(seq8[i]));
    dout_if.ready = 1'b0;
    for (int i = 4; i < 7; i++) send(DWI'(seq8[i]));
    check("held_word", 64'(dout_if.data), 64'h0_DDCC_BBAA);
    din_if.valid = 1'b1;
    din_if.data  = DWI'(8'h44);
    #1;
    check("stall_ready", 64'(din_if.ready), 64'd0);
    tick();
    check("stall_valid", 64'(dout_if.valid), 64'd1);
    check("stall_data", 64'(dout_if.data), 64'h0_DDCC_BBAA);
    dout_if.ready = 1'b1;
    #1;
    check("unstall_ready", 64'(din_if.ready), 64'd1);
    tick();
    din_if.valid = 1'b0;
    check("swap_valid", 64'(dout_if.valid), 64'd1);
    check("swap_data", 64'(dout_if.data), 64'h0_4433_2211);
    tick();
    check("swap_drain", 64'(dout_if.valid), 64'd0);

    // Reset discards a pending word and a partial word.
    dout_if.ready = 1'b0;
    for (int i = 4; i < 8; i++) send(DWI'(seq8[i]));
    send(DWI'(8'hAA));
    send(DWI'(8'hBB));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(dout_if.valid), 64'd0);
    dout_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(DWI'(i));
    check("post_rst_valid", 64'(dout_if.valid), 64'd1);
    check("post_rst_data", 64'(dout_if.data), 64'h0_0403_0201);
    tick();

`ifdef DESERIALIZE_EOT_EN
    send({1'b0, 8'hAA});
    send({1'b1, 8'hBB});
    check("eot_data", 64'(dout_if.data), 64'h1_0000_BBAA);
    for (int i = 4; i < 8; i++) send({1'b0, seq8[i]});
    check("eot_clear", 64'(dout_if.data), 64'h0_4433_2211);
    tick();
`endif

    // Randomized valid/ready against an in-order scoreboard.
    ci = 0; sent = 0; rcv = 0; cycles = 0;
    cur_word = $urandom;
    while (rcv < 1000 && cycles < 20000) begin
      din_if.valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      din_if.data   = DWI'(cur_word[ci*8 +: 8]);
      dout_if.ready = ($urandom_range(0, 9) < 7);
      #1;
      hs_in  = din_if.valid & din_if.ready;
      hs_out = dout_if.valid & dout_if.ready;
      if (hs_out) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : ~32'(dout_if.data);
        check("rand_word", 64'(dout_if.data), 64'(exp_w));
        rcv++;
      end
      if (hs_in) begin
        if (ci == 3) begin
          exp_q.push_back(cur_word);
          cur_word = $urandom;
          sent++;
          ci = 0;
        end else begin
          ci++;
        end
      end
      cycles++;
      @(posedge clk);
      #1;
    end
    din_if.valid = 1'b0;
    check("rand_count", 64'(rcv), 64'd1000);
    check("rand_leftover", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/deserialize.md
Name: deserialize

Overview:
- Downstream counterpart of the serializer stage.
- Collects RATIO = DOUT/DIN consecutive DIN-bit chunks from a dti stream and emits one DOUT-bit word per RATIO accepted chunks.
- Chunk order is LSB first: chunk k lands in bits [(k+1)*DIN-1 : k*DIN].
- A registered output stage lets the next word accumulate while the previous word waits on dout.ready, giving one-chunk-per-cycle throughput.

Parameters:
- DIN, 8, chunk width in bits; must be >= 1.
- DOUT, 32, output word width in bits; must be an integer multiple of DIN with DOUT/DIN >= 2. Elaboration-time $error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  dti.consumer  DIN  chunk stream (data, valid, ready).
- dout  dti.producer  DOUT  assembled word stream (data, valid, ready).

Behaviour:
- Constants: RATIO = DOUT/DIN; CW = max(1, $clog2(RATIO)).
- State:
  - cnt[CW-1:0], the index of the next chunk.
  - acc, the lower RATIO-1 chunks, (RATIO-1)*DIN bits.
  - out_data[DOUT-1:0] and out_valid, the output register.
- Reset: cnt=0, out_valid=0, dout.valid=0. acc and out_data are not reset; dout.data is don't-care while dout.valid=0.
- Derived signals:
  - last = (cnt == RATIO-1).
  - out_free = ~out_valid | dout.ready.
- Handshake:
  - din.ready = ~last | out_free.
  - dout.valid = out_valid; dout.data = out_data.
  - No combinational path from din.valid to dout.valid.
- Accept non-last chunk (din.valid & din.ready & ~last): write acc slot cnt with din.data, then cnt++.
- Accept last chunk:
  - out_data = {din.data, acc}, out_valid=1, cnt=0.
  - Latency: dout.valid rises the cycle after the last chunk is accepted.
- Output consumption: dout.valid & dout.ready with no simultaneous last-chunk accept sets out_valid=0.
- Simultaneous consume and last-chunk accept: out_valid stays 1 and out_data loads the new word, so there is no bubble.
- Backpressure:
  - Non-last chunks are accepted even while out_valid=1 and dout.ready=0.
  - The stall applies only at the last chunk.
  - din.ready may depend combinationally on dout.ready when cnt is at the last chunk.
- Counter wraps RATIO-1 -> 0. The counter never exceeds RATIO-1; unreachable values behave as non-last.
- Reset mid-word discards the partial word and any pending output word.
- din.data is sampled only on an accepted handshake; valid-without-ready holds all state.

Optional Feature:
- Macro: DESERIALIZE_EOT_EN.
- Defined:
  - din.data is DIN+1 bits; the MSB is eot, the payload is the low DIN bits.
  - dout.data is DOUT+1 bits; the MSB is eot.
  - An accepted chunk with eot=1 at any cnt completes the word immediately, using the last-chunk handshake rules for that chunk (din.ready requires out_free).
  - Completing the word early zero-fills the unfilled upper chunks, sets the dout eot bit to 1, and resets cnt to 0.
  - A word completed normally without eot has dout eot=0.
- Undefined: widths are DIN/DOUT, there is no early termination, and the behaviour is as above.

Decomposition:
- Package deserialize_pkg:
  - function cnt_width(ratio) returning max(1, $clog2(ratio)).
  - localparam EOT_W (1 if DESERIALIZE_EOT_EN defined, else 0).
- One natural sub-module: dti_word_reg, the output holding register. It has a load/consume handshake, a valid flag and data register, and exposes out_free. The accumulator and counter stay in deserialize.

Test Plan:
- DIN=8, DOUT=32, dout.ready=1, chunks AA,BB,CC,DD on consecutive cycles -> one cycle after DD is accepted, dout.valid=1 with data 0xDDCCBBAA; din.ready constant 1.
- Back-to-back words 0xDDCCBBAA then 0x44332211 with dout.ready=1 -> two dout beats 4 cycles apart, no din stall.
- dout.ready=0 after the first word; send 11,22,33,44 -> 11,22,33 accepted, 44 stalled (din.ready=0); dout.ready=1 for one cycle -> first word consumed and 44 accepted in the same cycle; next cycle dout.data=0x44332211.
- Assert rst after chunks AA,BB -> dout.valid=0, cnt=0; then send 01,02,03,04 -> output 0x04030201.
- Random din.valid/dout.ready with 1000 random words -> scoreboard matches every word in order, with no drops or duplicates.
- DESERIALIZE_EOT_EN defined: chunks AA, BB(eot=1) -> dout.data = {eot=1, 0x0000BBAA}; the following full word has eot=0.
